// File: rtl/sdram_arbit.sv
// sdram_arbit: arbitrates the SDRAM command bus between the power-up
// init sequencer, auto-refresh, write and read engines. Refresh has top
// priority. Simultaneous write/read requests alternate, using the last
// granted direction. Every grant returns through IDLE, so at least one
// NOP is issued between operations.
module sdram_arbit (
    input  logic        arb_clk,
    input  logic        arb_rst_n,
    input  logic        init_end,
    input  logic [18:0] init_ctl,
    input  logic        ar_req,
    input  logic        ar_end,
    input  logic [18:0] ar_ctl,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [18:0] wr_ctl,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [18:0] rd_ctl,
    output logic        ar_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [18:0] sdram_ctl,
    output logic [2:0]  arb_state
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    // {CS#,RAS#,CAS#,WE#} = 0111 (NOP), bank and address parked high
    localparam logic [18:0] NOP_CTL = {4'b0111, 2'b11, 13'h1fff};

    state_t state_q, state_d;
    // 0: write was granted last, 1: read was granted last
    logic   last_rw_q, last_rw_d;

    // State and write/read history registers
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, regardless of block order.
    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_q   <= S_INIT;
            last_rw_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_rw_q <= last_rw_d;
        end
    end

    // Next-state logic: fixed priority from IDLE, hold until own end pulse
    // NOTE: defaults are assigned first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        last_rw_d = last_rw_q;
        case (state_q)
            S_INIT: begin
                if (init_end) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (ar_req) begin
                    state_d = S_AREF;
                end else if (wr_req && rd_req) begin
                    // Tie: grant the direction not used last time
                    state_d = last_rw_q ? S_WRITE : S_READ;
                end else if (wr_req) begin
                    state_d = S_WRITE;
                end else if (rd_req) begin
                    state_d = S_READ;
                end
            end
            S_AREF: begin
                if (ar_end) state_d = S_IDLE;
            end
            S_WRITE: begin
                if (wr_end) state_d = S_IDLE;
            end
            S_READ: begin
                if (rd_end) state_d = S_IDLE;
            end
            default: begin
                // Unused encodings recover to IDLE
                state_d = S_IDLE;
            end
        endcase

        // History only moves when a write or read operation is entered
        if (state_q != S_WRITE && state_d == S_WRITE) last_rw_d = 1'b0;
        if (state_q != S_READ  && state_d == S_READ)  last_rw_d = 1'b1;
    end

    // Grant decode and command bus mux, both purely from the current state
    always_comb begin
        ar_en     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        sdram_ctl = NOP_CTL;
        case (state_q)
            S_INIT:  sdram_ctl = init_ctl;
            S_IDLE:  sdram_ctl = NOP_CTL;
            S_AREF: begin
                ar_en     = 1'b1;
                sdram_ctl = ar_ctl;
            end
            S_WRITE: begin
                wr_en     = 1'b1;
                sdram_ctl = wr_ctl;
            end
            S_READ: begin
                rd_en     = 1'b1;
                sdram_ctl = rd_ctl;
            end
            default: sdram_ctl = NOP_CTL;
        endcase
    end

    assign arb_state = state_q;

endmodule
